ras_ctrl: RTL and testbench

- Fetch-side controller that sits directly upstream of the return-address stack (RAS) and drives its push, pop, pushee, restoreTail and newTail inputs.
- Decodes AArch64 calls (BL, BLR) and returns (RET) from the fetch stream, pushes return addresses and forwards the RAS top as the predicted return target.
- Keeps an in-order checkpoint ring of speculative RAS tail values, one per in-flight control-flow instruction, so a backend mispredict restores the RAS pointer in one cycle.

---
 rtl/ras_ctrl_if.sv | 44 ++++
 rtl/ras_ctrl.sv | 109 ++++++++++
 tb/tb_ras_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ras_ctrl_if.sv
// Fetch, RAS and backend signal bundle for ras_ctrl.
// The master side is the fetch/RAS/backend environment; the slave is ras_ctrl.
interface ras_ctrl_if #(
    parameter int ENTRY_SIZE = 64,
    parameter int TW         = 3,
    parameter int GW         = 4
);
    logic                  fetch_valid;
    logic [ENTRY_SIZE-1:0] fetch_pc;
    logic [31:0]           fetch_insn;
    logic                  fetch_is_branch;
    logic                  fetch_ready;

    logic [ENTRY_SIZE-1:0] ras_top;
    logic                  ras_push;
    logic                  ras_pop;
    logic [ENTRY_SIZE-1:0] ras_pushee;
    logic                  ras_restore;
    logic [TW-1:0]         ras_new_tail;

    logic                  pred_valid;
    logic [ENTRY_SIZE-1:0] pred_target;

    logic [GW-1:0]         ckpt_tag;
    logic                  ckpt_alloc;
    logic                  commit_valid;
    logic                  flush_valid;
    logic [GW-1:0]         flush_tag;
    logic [GW:0]           ckpt_count;

    modport master (
        output fetch_valid, fetch_pc, fetch_insn, fetch_is_branch, ras_top,
               commit_valid, flush_valid, flush_tag,
        input  fetch_ready, ras_push, ras_pop, ras_pushee, ras_restore, ras_new_tail,
               pred_valid, pred_target, ckpt_tag, ckpt_alloc, ckpt_count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_insn, fetch_is_branch, ras_top,
               commit_valid, flush_valid, flush_tag,
        output fetch_ready, ras_push, ras_pop, ras_pushee, ras_restore, ras_new_tail,
               pred_valid, pred_target, ckpt_tag, ckpt_alloc, ckpt_count
    );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack front controller: decodes calls/returns, drives the RAS,
// and keeps an in-order ring of speculative RAS tails for one-cycle mispredict repair.
module ras_ctrl #(
    parameter  int STACK_DEPTH = 8,
    parameter  int ENTRY_SIZE  = 64,
    parameter  int CKPT_DEPTH  = 16,
    localparam int TW          = $clog2(STACK_DEPTH),
    localparam int GW          = $clog2(CKPT_DEPTH)
) (
    input  logic      clk_in,
    input  logic      rst_in,
    ras_ctrl_if.slave bus
);
    localparam logic [GW:0]   FULL     = (GW+1)'(CKPT_DEPTH);
    localparam logic [TW-1:0] TAIL_MAX = TW'(STACK_DEPTH - 1);

    logic [TW-1:0] spec_tail_q, spec_tail_d;
    logic [GW-1:0] head_q, head_d;
    logic [GW-1:0] alloc_q, alloc_d;
    logic [GW:0]   count_q, count_d;
    logic [TW-1:0] ckpt_q [CKPT_DEPTH];
    logic [TW-1:0] ckpt_d [CKPT_DEPTH];

    logic          is_call, is_ret, is_ctrl;
    logic          ready, acc;
    logic          do_call, do_ret, do_alloc;
    logic [TW-1:0] tail_inc, tail_dec, tail_post;
    logic [GW-1:0] flush_dist;
    logic          flush_live;
    logic [TW-1:0] restore_tail;
    logic          commit_eff;
    logic [GW:0]   count_base;

    // BL | BLR, and RET; BLR and RET differ in bit 21 so they never both match.
    assign is_call = ((bus.fetch_insn & 32'hFC00_0000) == 32'h9400_0000) ||
                     ((bus.fetch_insn & 32'hFFFF_FC1F) == 32'hD63F_0000);
    assign is_ret  = (bus.fetch_insn & 32'hFFFF_FC1F) == 32'hD65F_0000;
    assign is_ctrl = is_call || is_ret || bus.fetch_is_branch;

    // A full ring only holds back instructions that would need a checkpoint.
    assign ready    = !rst_in && !bus.flush_valid && ((count_q < FULL) || !is_ctrl);
    assign acc      = bus.fetch_valid && ready;
    assign do_call  = acc && is_call;
    assign do_ret   = acc && is_ret && !is_call;
    assign do_alloc = acc && is_ctrl;

    // Wrap explicitly so a non-power-of-two stack still tracks the RAS pointer.
    assign tail_inc = (spec_tail_q == TAIL_MAX) ? '0 : spec_tail_q + TW'(1);
    assign tail_dec = (spec_tail_q == '0) ? TAIL_MAX : spec_tail_q - TW'(1);

    always_comb begin
        tail_post = spec_tail_q;
        if (do_call)     tail_post = tail_inc;
        else if (do_ret) tail_post = tail_dec;
    end

    // A tag is live when its ring distance from head is below the live count.
    assign flush_dist   = bus.flush_tag - head_q;
    assign flush_live   = !rst_in && bus.flush_valid && ({1'b0, flush_dist} < count_q);
    assign restore_tail = ckpt_q[bus.flush_tag];
    assign commit_eff   = bus.commit_valid && (count_q != '0);

    always_comb begin
        spec_tail_d = tail_post;
        alloc_d     = alloc_q;
        ckpt_d      = ckpt_q;
        count_base  = count_q;
        if (do_alloc) begin
            ckpt_d[alloc_q] = tail_post;
            alloc_d         = alloc_q + GW'(1);
            count_base      = count_q + (GW+1)'(1);
        end
        // Flush and allocate are exclusive: flush forces fetch_ready low.
        if (flush_live) begin
            spec_tail_d = restore_tail;
            alloc_d     = bus.flush_tag + GW'(1);
            count_base  = {1'b0, flush_dist} + (GW+1)'(1);
        end
        count_d = count_base - (GW+1)'(commit_eff);
        head_d  = head_q + GW'(commit_eff);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            spec_tail_q <= '0;
            head_q      <= '0;
            alloc_q     <= '0;
            count_q     <= '0;
        end else begin
            spec_tail_q <= spec_tail_d;
            head_q      <= head_d;
            alloc_q     <= alloc_d;
            count_q     <= count_d;
        end
        ckpt_q <= ckpt_d;
    end

    assign bus.fetch_ready  = ready;
    assign bus.ras_push     = do_call;
    assign bus.ras_pushee   = do_call ? bus.fetch_pc + ENTRY_SIZE'(4) : '0;
    assign bus.ras_pop      = do_ret;
    assign bus.pred_valid   = do_ret;
    assign bus.pred_target  = do_ret ? bus.ras_top : '0;
    assign bus.ras_restore  = flush_live;
    assign bus.ras_new_tail = flush_live ? restore_tail : '0;
    assign bus.ckpt_alloc   = do_alloc;
    assign bus.ckpt_tag     = do_alloc ? alloc_q : '0;
    assign bus.ckpt_count   = count_q;
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: call/return, tail wrap, full ring, flush, commit, reset.
module tb_ras_ctrl;
    localparam logic [31:0] BL    = 32'h9400_0010;
    localparam logic [31:0] BLR   = 32'hD63F_0020;
    localparam logic [31:0] RET   = 32'hD65F_03C0;
    localparam logic [31:0] BCOND = 32'h5400_0040;
    localparam logic [31:0] ADD   = 32'h8B02_0020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ras_ctrl_if #(.ENTRY_SIZE(64), .TW(3), .GW(4)) bus ();

    ras_ctrl #(.STACK_DEPTH(8), .ENTRY_SIZE(64), .CKPT_DEPTH(16)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.fetch_valid     = 1'b0;
        bus.fetch_pc        = '0;
        bus.fetch_insn      = ADD;
        bus.fetch_is_branch = 1'b0;
        bus.ras_top         = '0;
        bus.commit_valid    = 1'b0;
        bus.flush_valid     = 1'b0;
        bus.flush_tag       = '0;
    endtask

    task automatic fetch(input logic [31:0] insn, input logic [63:0] pc, input logic br);
        idle();
        bus.fetch_valid     = 1'b1;
        bus.fetch_insn      = insn;
        bus.fetch_pc        = pc;
        bus.fetch_is_branch = br;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic go();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        go();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        // Reset: outputs forced low even with a call and a flush presented.
        fetch(BL, 64'h1000, 1'b0);
        bus.flush_valid = 1'b1;
        #1;
        chk("rst_ready", bus.fetch_ready, 0);
        chk("rst_push", bus.ras_push, 0);
        chk("rst_restore", bus.ras_restore, 0);
        go();
        idle();
        rst = 1'b0;
        chk("rst_count", bus.ckpt_count, 0);

        // BL then RET, then underflowing RET.
        fetch(BL, 64'h1000, 1'b0); #1;
        chk("bl_push", bus.ras_push, 1);
        chk("bl_pushee", bus.ras_pushee, 64'h1004);
        chk("bl_pop", bus.ras_pop, 0);
        chk("bl_tag", bus.ckpt_tag, 0);
        chk("bl_alloc", bus.ckpt_alloc, 1);
        go();
        chk("bl_tail", dut.spec_tail_q, 1);
        fetch(RET, 64'h1004, 1'b0); bus.ras_top = 64'h1004; #1;
        chk("ret_pop", bus.ras_pop, 1);
        chk("ret_pv", bus.pred_valid, 1);
        chk("ret_tgt", bus.pred_target, 64'h1004);
        chk("ret_push", bus.ras_push, 0);
        chk("ret_tag", bus.ckpt_tag, 1);
        go();
        chk("ret_tail", dut.spec_tail_q, 0);
        fetch(RET, 64'h2000, 1'b0); bus.ras_top = 64'h55; #1;
        chk("ret2_tgt", bus.pred_target, 64'h55);
        go();
        chk("ret2_tail", dut.spec_tail_q, 7);
        chk("ret2_count", bus.ckpt_count, 3);
        for (int i = 0; i < 4; i++) begin
            idle(); bus.commit_valid = 1'b1; go();
        end
        chk("commit_empty", bus.ckpt_count, 0);

        // Nine calls wrap the tail 7->0->1.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            fetch(BL, 64'h100 + 64'(i * 4), 1'b0); #1;
            chk("bl9_ready", bus.fetch_ready, 1);
            chk("bl9_tag", bus.ckpt_tag, 64'(i));
            go();
        end
        chk("bl9_tail", dut.spec_tail_q, 1);
        chk("bl9_count", bus.ckpt_count, 9);
        idle(); bus.flush_valid = 1'b1; bus.flush_tag = 4'd8; #1;
        chk("fl8_restore", bus.ras_restore, 1);
        chk("fl8_tail", bus.ras_new_tail, 1);
        go();
        idle(); bus.flush_valid = 1'b1; bus.flush_tag = 4'd7; #1;
        chk("fl7_tail", bus.ras_new_tail, 0);
        go();
        chk("fl7_count", bus.ckpt_count, 8);
        fetch(BLR, 64'h2000, 1'b0); #1;
        chk("blr_push", bus.ras_push, 1);
        chk("blr_pushee", bus.ras_pushee, 64'h2004);
        chk("blr_tag", bus.ckpt_tag, 8);
        go();
        chk("blr_tail", dut.spec_tail_q, 1);

        // Full ring stalls branches only.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fetch(BCOND, 64'h400, 1'b1); go();
        end
        chk("full_count", bus.ckpt_count, 16);
        fetch(BCOND, 64'h440, 1'b1); #1;
        chk("full_br_ready", bus.fetch_ready, 0);
        chk("full_br_alloc", bus.ckpt_alloc, 0);
        fetch(ADD, 64'h440, 1'b0); #1;
        chk("full_add_ready", bus.fetch_ready, 1);
        chk("full_add_alloc", bus.ckpt_alloc, 0);
        chk("full_add_push", bus.ras_push, 0);
        go();
        fetch(BCOND, 64'h444, 1'b1); bus.commit_valid = 1'b1; #1;
        chk("full_cm_ready", bus.fetch_ready, 0);
        go();
        fetch(BCOND, 64'h444, 1'b1); bus.commit_valid = 1'b1; #1;
        chk("after_cm_ready", bus.fetch_ready, 1);
        chk("after_cm_tag", bus.ckpt_tag, 0);
        go();
        chk("cm_alloc_count", bus.ckpt_count, 15);

        // Flush mid-ring blocks the concurrent fetch.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(BL, 64'h800, 1'b0); go();
        end
        fetch(BL, 64'h900, 1'b0); bus.flush_valid = 1'b1; bus.flush_tag = 4'd1; #1;
        chk("fl1_restore", bus.ras_restore, 1);
        chk("fl1_tail", bus.ras_new_tail, 2);
        chk("fl1_ready", bus.fetch_ready, 0);
        chk("fl1_push", bus.ras_push, 0);
        go();
        chk("fl1_count", bus.ckpt_count, 2);
        chk("fl1_spec", dut.spec_tail_q, 2);
        fetch(BL, 64'h900, 1'b0); #1;
        chk("fl1_next_tag", bus.ckpt_tag, 2);
        go();
        chk("fl1_next_spec", dut.spec_tail_q, 3);

        // Commit + flush of the head, then a stale flush.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(BL, 64'h800, 1'b0); go();
        end
        idle(); bus.commit_valid = 1'b1; bus.flush_valid = 1'b1; bus.flush_tag = 4'd0; #1;
        chk("flh_tail", bus.ras_new_tail, 1);
        go();
        chk("flh_count", bus.ckpt_count, 0);
        idle(); bus.flush_valid = 1'b1; bus.flush_tag = 4'd5; #1;
        chk("stale_restore", bus.ras_restore, 0);
        chk("stale_tail", bus.ras_new_tail, 0);
        go();
        fetch(BL, 64'hA00, 1'b0); #1;
        chk("flh_next_tag", bus.ckpt_tag, 1);
        go();
        chk("flh_next_spec", dut.spec_tail_q, 2);

        // Reset mid-operation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch(BL, 64'hC00, 1'b0); go();
        end
        fetch(RET, 64'hC10, 1'b0); bus.ras_top = 64'h77; bus.flush_valid = 1'b1;
        rst = 1'b1; #1;
        chk("mrst_ready", bus.fetch_ready, 0);
        chk("mrst_pop", bus.ras_pop, 0);
        chk("mrst_pv", bus.pred_valid, 0);
        chk("mrst_tgt", bus.pred_target, 0);
        chk("mrst_alloc", bus.ckpt_alloc, 0);
        chk("mrst_restore", bus.ras_restore, 0);
        go();
        rst = 1'b0;
        chk("mrst_count", bus.ckpt_count, 0);
        chk("mrst_spec", dut.spec_tail_q, 0);
        fetch(BL, 64'hD00, 1'b0); #1;
        chk("mrst_tag", bus.ckpt_tag, 0);
        chk("mrst_alloc1", bus.ckpt_alloc, 1);
        go();
        chk("mrst_spec1", dut.spec_tail_q, 1);
        idle();
        go();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
